// File: rtl/led_anim_ctrl.sv
// Row-scan timebase and tear-free frame sequencer for the 8x8 LED matrix.
// Define PINGPONG_EN to bounce between the end frames instead of wrapping.
module led_anim_ctrl #(
    parameter int CLK_DIV_SCAN    = 1000,
    parameter int SCANS_PER_FRAME = 50,
    parameter int NUM_FRAMES      = 4,
    parameter int SEL_W           = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic             dir,
    input  logic             loop_en,
    output logic             scan_tick,
    output logic [2:0]       row_idx,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             frame_wrap
);
    localparam int PW = (CLK_DIV_SCAN > 1) ? $clog2(CLK_DIV_SCAN) : 1;
    localparam int HW = (SCANS_PER_FRAME > 1) ? $clog2(SCANS_PER_FRAME) : 1;
    localparam logic [PW-1:0]    P_LAST = PW'(CLK_DIV_SCAN - 1);
    localparam logic [HW-1:0]    H_LAST = HW'(SCANS_PER_FRAME - 1);
    localparam logic [SEL_W-1:0] F_LAST = SEL_W'(NUM_FRAMES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PLAY  = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [2:0]       row_q, row_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             pend_q, pend_d;
    logic             wrap_q, wrap_d;
`ifdef PINGPONG_EN
    logic             dir_q, dir_d;
`endif

    logic             tick, scan_done, go, do_adv;
    logic             adv_dir, at_end, adv_wrap, adv_end;
    logic [SEL_W-1:0] adv_sel;

    always_comb begin
        tick      = (presc_q == P_LAST);
        scan_done = tick && (row_q == 3'd7);
        presc_d   = tick ? '0 : presc_q + 1'b1;
        row_d     = tick ? row_q + 3'd1 : row_q;

        // Candidate next frame, evaluated every cycle, used only on an advance
`ifdef PINGPONG_EN
        adv_dir = dir_q;
`else
        adv_dir = dir;
`endif
        at_end   = adv_dir ? (sel_q == '0) : (sel_q == F_LAST);
        adv_sel  = adv_dir ? sel_q - 1'b1 : sel_q + 1'b1;
        adv_wrap = 1'b0;
        adv_end  = 1'b0;
        if (at_end && loop_en) begin
            adv_wrap = 1'b1;
`ifdef PINGPONG_EN
            adv_sel = adv_dir ? sel_q + 1'b1 : sel_q - 1'b1;
`else
            adv_sel = adv_dir ? F_LAST : '0;
`endif
        end else if (at_end) begin
            adv_sel = sel_q;
            adv_end = 1'b1;
        end

        go      = start && !stop;
        do_adv  = 1'b0;
        state_d = state_q;
        sel_d   = sel_q;
        hold_d  = hold_q;
        pend_d  = pend_q;
        wrap_d  = 1'b0;
`ifdef PINGPONG_EN
        dir_d   = dir_q;
`endif

        unique case (state_q)
            S_PLAY: begin
                if (scan_done) begin
                    do_adv = (hold_q == H_LAST);
                    hold_d = do_adv ? '0 : hold_q + 1'b1;
                end
            end
            S_PAUSE: begin
                if (go) begin
                    state_d = S_PLAY;
                    pend_d  = 1'b0;
                end else if (pend_q && scan_done) begin
                    do_adv = 1'b1;
                    pend_d = 1'b0;
                end else if (step && !stop) begin
                    pend_d = 1'b1;
                end
            end
            default: begin
                if (go) begin
                    state_d = S_PLAY;
                    sel_d   = dir ? F_LAST : '0;
                    hold_d  = '0;
                    pend_d  = 1'b0;
`ifdef PINGPONG_EN
                    dir_d   = dir;
`endif
                end
            end
        endcase

        if (do_adv) begin
            sel_d  = adv_sel;
            wrap_d = adv_wrap;
`ifdef PINGPONG_EN
            dir_d  = adv_wrap ? !dir_q : dir_q;
`endif
            if (adv_end) state_d = S_DONE;
        end
        // A stop still lets a coincident advance land before pausing
        if (state_q == S_PLAY && stop) state_d = S_PAUSE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            row_q   <= '0;
            hold_q  <= '0;
            sel_q   <= '0;
            pend_q  <= 1'b0;
            wrap_q  <= 1'b0;
`ifdef PINGPONG_EN
            dir_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            row_q   <= row_d;
            hold_q  <= hold_d;
            sel_q   <= sel_d;
            pend_q  <= pend_d;
            wrap_q  <= wrap_d;
`ifdef PINGPONG_EN
            dir_q   <= dir_d;
`endif
        end
    end

    assign scan_tick  = tick;
    assign row_idx    = row_q;
    assign sel        = sel_q;
    assign busy       = (state_q == S_PLAY);
    assign frame_wrap = wrap_q;
endmodule

// File: tb/tb_led_anim_ctrl.sv
// Bench for led_anim_ctrl: directed scenarios plus random control traffic
// against a cycle-count based behavioural model.
module tb_led_anim_ctrl;
    localparam int CD  = 4;
    localparam int SPF = 2;
    localparam int NF  = 4;
    localparam int SW  = 2;
    localparam int IDLE = 0, PLAY = 1, PAUSE = 2, DONE = 3;

    logic clk = 0, rst = 0;
    logic start = 0, stop = 0, step = 0, dir = 0, loop_en = 0;
    logic          scan_tick;
    logic [2:0]    row_idx;
    logic [SW-1:0] sel;
    logic          busy, frame_wrap;

    led_anim_ctrl #(
        .CLK_DIV_SCAN(CD), .SCANS_PER_FRAME(SPF),
        .NUM_FRAMES(NF), .SEL_W(SW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .step(step),
        .dir(dir), .loop_en(loop_en), .scan_tick(scan_tick),
        .row_idx(row_idx), .sel(sel), .busy(busy), .frame_wrap(frame_wrap)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int cnt, m_st, m_sel, m_hold;
    bit m_pend, m_dir, m_wrap;
    int q[$];
    int wraps, badrow, nidle, nticks;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        cnt = 0; m_st = IDLE; m_sel = 0; m_hold = 0;
        m_pend = 0; m_dir = 0; m_wrap = 0;
    endtask

    // Next frame from the travel direction; fin = one-shot end reached
    task automatic adv(input bit d, output int ns, output bit w, output bit fin, output bit nd);
        int last;
        last = d ? 0 : NF - 1;
        ns = m_sel; w = 0; fin = 0; nd = d;
        if (m_sel != last) ns = d ? m_sel - 1 : m_sel + 1;
        else if (!loop_en) fin = 1;
        else begin
            w = 1;
`ifdef PINGPONG_EN
            nd = !d;
            ns = d ? 1 : NF - 2;
`else
            ns = d ? NF - 1 : 0;
`endif
        end
    endtask

    task automatic model_edge();
        bit sdone, de, w, fin, nd;
        int ns;
        sdone = (cnt % (8 * CD)) == 8 * CD - 1;
`ifdef PINGPONG_EN
        de = m_dir;
`else
        de = dir;
`endif
        m_wrap = 0;
        if (m_st == PLAY) begin
            if (sdone) begin
                if (m_hold == SPF - 1) begin
                    m_hold = 0;
                    adv(de, ns, w, fin, nd);
                    m_sel = ns; m_wrap = w; m_dir = nd;
                    if (fin) m_st = DONE;
                end else m_hold++;
            end
            if (stop) m_st = PAUSE;
        end else if (m_st == PAUSE) begin
            if (start && !stop) begin
                m_st = PLAY; m_pend = 0;
            end else if (m_pend && sdone) begin
                adv(de, ns, w, fin, nd);
                m_sel = ns; m_wrap = w; m_dir = nd; m_pend = 0;
                if (fin) m_st = DONE;
            end else if (step && !stop) m_pend = 1;
        end else if (start && !stop) begin
            m_st = PLAY; m_sel = dir ? NF - 1 : 0;
            m_hold = 0; m_pend = 0; m_dir = dir;
        end
        cnt++;
    endtask

    task automatic compare();
        chk("scan_tick", scan_tick, (cnt % CD) == CD - 1);
        chk("row_idx", row_idx, (cnt / CD) % 8);
        chk("sel", sel, m_sel);
        chk("busy", busy, m_st == PLAY);
        chk("frame_wrap", frame_wrap, m_wrap);
    endtask

    task automatic tick_cyc();
        @(posedge clk);
        if (rst) model_edge();
        #1;
        compare();
        start = 0; stop = 0; step = 0;
    endtask

    task automatic do_reset(input int n);
        rst = 0;
        #1;
        model_reset();
        compare();
        chk("rst_sel", sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_row", row_idx, 0);
        chk("rst_tick", scan_tick, 0);
        chk("rst_wrap", frame_wrap, 0);
        repeat (n) begin
            @(posedge clk);
            #1;
            compare();
        end
        rst = 1;
    endtask

    task automatic run_rec(input int n);
        logic [SW-1:0] prev;
        q.delete();
        wraps = 0; badrow = 0; nidle = 0; nticks = 0;
        prev = sel;
        repeat (n) begin
            tick_cyc();
            if (frame_wrap) wraps++;
            if (!busy) nidle++;
            if (scan_tick) nticks++;
            if (sel !== prev) begin
                q.push_back(int'(sel));
                if (row_idx !== 3'd0) badrow++;
                prev = sel;
            end
        end
    endtask

    task automatic wait_sel(input int v, input int lim);
        int k = 0;
        while (sel !== SW'(v) && k < lim) begin
            tick_cyc();
            k++;
        end
        chk("wait_sel", sel, v);
    endtask

    int fexp[7];
    int rexp[3] = '{2, 1, 0};

    initial begin
`ifdef PINGPONG_EN
        fexp = '{1, 2, 3, 2, 1, 0, 1};
`else
        fexp = '{1, 2, 3, 0, 1, 2, 3};
`endif
        do_reset(3);

        // Idle timebase
        run_rec(64);
        chk("tb_ticks", nticks, 16);
        chk("tb_changes", q.size(), 0);
        chk("tb_busy_low", nidle, 64);

        // Forward looping playback
        dir = 0; loop_en = 1; start = 1;
        tick_cyc();
        chk("fwd_first", sel, 0);
        run_rec(7 * 64 + 10);
        chk("fwd_n", q.size(), 7);
        for (int i = 0; i < 7; i++)
            chk("fwd_seq", (i < q.size()) ? q[i] : -1, fexp[i]);
`ifdef PINGPONG_EN
        chk("fwd_wraps", wraps, 2);
`else
        chk("fwd_wraps", wraps, 1);
`endif
        chk("fwd_row0", badrow, 0);
        chk("fwd_busy", nidle, 0);

        // One-shot reverse, then restart from DONE
        do_reset(2);
        dir = 1; loop_en = 0; start = 1;
        tick_cyc();
        chk("rev_first", sel, 3);
        run_rec(5 * 64);
        chk("rev_n", q.size(), 3);
        for (int i = 0; i < 3; i++)
            chk("rev_seq", (i < q.size()) ? q[i] : -1, rexp[i]);
        chk("rev_done_busy", busy, 0);
        chk("rev_done_sel", sel, 0);
        start = 1;
        tick_cyc();
        chk("rev_restart", sel, 3);
        chk("rev_restart_busy", busy, 1);

        // Pause, frozen frame, single step, ignored duplicate step
        do_reset(2);
        dir = 0; loop_en = 1; start = 1;
        tick_cyc();
        wait_sel(1, 200);
        stop = 1;
        tick_cyc();
        run_rec(200);
        chk("pause_frozen", q.size(), 0);
        chk("pause_sel", sel, 1);
        for (int k = 0; k < 40 && (cnt % 32) != 1; k++) tick_cyc();
        step = 1;
        tick_cyc();
        tick_cyc();
        tick_cyc();
        step = 1;
        tick_cyc();
        wait_sel(2, 40);
        chk("step_row0", row_idx, 0);
        run_rec(40);
        chk("step_dup", q.size(), 0);
        start = 1;
        tick_cyc();
        chk("resume_busy", busy, 1);

        // Stop beats start; reset mid-frame
        stop = 1; start = 1;
        tick_cyc();
        chk("prio_busy", busy, 0);
        do_reset(2);
        dir = 0; loop_en = 1; start = 1;
        tick_cyc();
        wait_sel(2, 200);
        repeat (10) tick_cyc();
        chk("pre_rst_sel", sel, 2);
        do_reset(2);

        // Random control traffic
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom_range(0, 59) == 0);
            stop  = ($urandom_range(0, 79) == 0);
            step  = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 199) == 0) dir = ~dir;
            if ($urandom_range(0, 299) == 0) loop_en = ~loop_en;
            if ($urandom_range(0, 1499) == 0) do_reset(2);
            else tick_cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
